// File: rtl/pio_pkg.sv
// pio_pkg
// Shared definitions for the Avalon-MM input PIO family: register window
// offsets, the capture-edge selector and the interrupt source selector.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        ANY  = 2'd2
    } edge_type_e;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/pio_input_sync.sv
// pio_input_sync
// Brings WIDTH asynchronous input bits into the clk domain through
// SYNC_STAGES flops and keeps one extra delayed copy for edge detection.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset, clears every flop
//   in_port  raw input bits, asynchronous to clk
//   sync     in_port delayed by SYNC_STAGES flops (in_port itself when 0)
//   prev     sync delayed by one further flop
module pio_input_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] prev
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            // Input already synchronous to clk; no metastability filtering.
            assign sync = in_port;
        end else begin : g_chain
            logic [WIDTH-1:0] stages [SYNC_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign sync = stages[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

endmodule

// File: rtl/avalon_pio_in_irq.sv
// avalon_pio_in_irq
// Parametrised Avalon-MM input PIO slave with synchroniser, per-bit edge
// capture, interrupt mask and irq output.
//
// Register window (word address):
//   0 data        synchronised input level, read only
//   1 reserved    reads 0
//   2 irqmask     read/write
//   3 edgecapture read, write-1-to-clear
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write/select signals
//   readdata              registered read data, 1-cycle latency
//   in_port               external input bits
//   irq                   active-high interrupt request
module avalon_pio_in_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits are meaningless when WIDTH < 32.
    assign unused_wdata = ^writedata;

    pio_input_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .sync    (sync),
        .prev    (prev)
    );

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        edge_vec = sync & ~prev;
        if (EDGE_TYPE == int'(FALL)) begin
            edge_vec = ~sync & prev;
        end else if (EDGE_TYPE == int'(ANY)) begin
            edge_vec = sync ^ prev;
        end
    end

    assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge is OR-ed in after the clear so a colliding edge is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~edge_clr) | edge_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // The read mux ignores chipselect; readdata simply tracks the address.
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = sync;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    // Both sources are flop outputs, so irq never follows bus inputs combinationally.
    assign irq = (IRQ_MODE == int'(EDGE)) ? |(edgecapture & irqmask)
                                          : |(sync & irqmask);

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// tb_avalon_pio_in_irq
// Three instances share one bus and in_port: rising/edge-irq,
// falling/level-irq and any/edge-irq, all WIDTH 8, SYNC_STAGES 2.
module tb_avalon_pio_in_irq;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  rdOut [3];
    logic         irqOut [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state.
    int           edgeCfg [3] = '{0, 1, 2};
    int           irqCfg  [3] = '{1, 0, 1};
    logic [W-1:0] hist [$];
    logic [W-1:0] mEc   [3];
    logic [W-1:0] mMask [3];
    logic [31:0]  mRd   [3];

    always #5 clk = ~clk;

    avalon_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .IRQ_MODE(1)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdOut[0]), .irq(irqOut[0]));

    avalon_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1), .IRQ_MODE(0)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdOut[1]), .irq(irqOut[1]));

    avalon_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .IRQ_MODE(1)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdOut[2]), .irq(irqOut[2]));

    // hist holds the last SS+1 in_port samples, newest at the back.
    function automatic logic [W-1:0] syncNow();
        return hist[hist.size() - SS];
    endfunction

    function automatic logic [W-1:0] prevNow();
        return hist[hist.size() - SS - 1];
    endfunction

    function automatic logic [W-1:0] edgesOf(int k, logic [W-1:0] s, logic [W-1:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (edgeCfg[k] == 0)      r[b] = !p[b] && s[b];
            else if (edgeCfg[k] == 1) r[b] = p[b] && !s[b];
            else                      r[b] = p[b] != s[b];
        end
        return r;
    endfunction

    function automatic logic expIrq(int k);
        if (irqCfg[k] == 1) return |(mEc[k] & mMask[k]);
        return |(syncNow() & mMask[k]);
    endfunction

    task automatic clearModel();
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
        for (int k = 0; k < 3; k++) begin
            mEc[k]   = '0;
            mMask[k] = '0;
            mRd[k]   = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rd%0d@%0d", k, cyc), rdOut[k], mRd[k]);
            checkOutput($sformatf("irq%0d@%0d", k, cyc), {31'b0, irqOut[k]}, {31'b0, expIrq(k)});
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn,
                                 input logic [31:0] wd, input logic [W-1:0] inp);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = inp;
    endtask

    // Advance one clock: predict from pre-edge values, commit, check at negedge.
    task automatic tick();
        logic [W-1:0] s, p, clr;
        logic [W-1:0] nEc [3];
        logic [W-1:0] nMask [3];
        logic [31:0]  nRd [3];
        bit wr;
        s  = syncNow();
        p  = prevNow();
        wr = chipselect && !write_n;
        for (int k = 0; k < 3; k++) begin
            case (address)
                2'd0:    nRd[k] = {{(32-W){1'b0}}, s};
                2'd2:    nRd[k] = {{(32-W){1'b0}}, mMask[k]};
                2'd3:    nRd[k] = {{(32-W){1'b0}}, mEc[k]};
                default: nRd[k] = '0;
            endcase
            clr      = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            nEc[k]   = (mEc[k] & ~clr) | edgesOf(k, s, p);
            nMask[k] = (wr && address == 2'd2) ? writedata[W-1:0] : mMask[k];
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            clearModel();
        end else begin
            for (int k = 0; k < 3; k++) begin
                mEc[k]   = nEc[k];
                mMask[k] = nMask[k];
                mRd[k]   = nRd[k];
            end
            hist.push_back(in_port);
            void'(hist.pop_front());
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic readAt(input logic [1:0] a, input logic [W-1:0] inp);
        applyStimulus(a, 1'b0, 1'b1, 32'h0, inp);
    endtask

    task automatic writeAt(input logic [1:0] a, input logic [31:0] wd, input logic [W-1:0] inp);
        applyStimulus(a, 1'b1, 1'b0, wd, inp);
    endtask

    task automatic asyncReset();
        reset = 1'b1;
        clearModel();
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_rd%0d", k), rdOut[k], 32'h0);
            checkOutput($sformatf("rst_irq%0d", k), {31'b0, irqOut[k]}, 32'h0);
        end
    endtask

    initial begin
        clearModel();
        #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("init_rd%0d", k), rdOut[k], 32'h0);
            checkOutput($sformatf("init_irq%0d", k), {31'b0, irqOut[k]}, 32'h0);
        end
        ticks(2);
        reset = 1'b0;
        readAt(2'd1, 8'h00);
        ticks(4);

        // Level read: 0x00 -> 0xA5 visible only at the third edge.
        $display("[TB] level read");
        readAt(2'd0, 8'hA5);
        tick();
        checkOutput("lvl_e0", rdOut[0], 32'h0);
        tick();
        checkOutput("lvl_e1", rdOut[0], 32'h0);
        tick();
        checkOutput("lvl_e2", rdOut[0], 32'h000000A5);

        // Edge capture plus irq on bit0.
        $display("[TB] edge capture and irq");
        writeAt(2'd2, 32'h1, 8'hA5);
        tick();
        readAt(2'd0, 8'h00);
        ticks(4);
        writeAt(2'd3, 32'hFF, 8'h00);
        tick();
        readAt(2'd3, 8'h01);
        ticks(2);
        checkOutput("eirq_e1", {31'b0, irqOut[0]}, 32'h0);
        tick();
        checkOutput("eirq_e2", {31'b0, irqOut[0]}, 32'h1);
        tick();
        checkOutput("ecap_rd", rdOut[0], 32'h1);
        writeAt(2'd3, 32'h1, 8'h01);
        tick();
        checkOutput("eirq_clr", {31'b0, irqOut[0]}, 32'h0);

        // Set-wins: bit3 rising edge captured on the same edge as its clear.
        $display("[TB] set-wins collision");
        readAt(2'd3, 8'h09);
        ticks(2);
        writeAt(2'd3, 32'h8, 8'h09);
        tick();
        readAt(2'd3, 8'h09);
        tick();
        checkOutput("setwins", rdOut[0], 32'h8);
        writeAt(2'd3, 32'h8, 8'h09);
        tick();
        readAt(2'd3, 8'h09);
        tick();
        checkOutput("clr2", rdOut[0], 32'h0);

        // Level-mode masking on dut1.
        $display("[TB] level mode masking");
        writeAt(2'd2, 32'h4, 8'h09);
        tick();
        readAt(2'd0, 8'h02);
        ticks(3);
        checkOutput("lirq_off", {31'b0, irqOut[1]}, 32'h0);
        readAt(2'd0, 8'h06);
        ticks(2);
        checkOutput("lirq_on", {31'b0, irqOut[1]}, 32'h1);
        writeAt(2'd2, 32'h0, 8'h06);
        tick();
        checkOutput("lirq_mask0", {31'b0, irqOut[1]}, 32'h0);

        // Falling and any edge types.
        $display("[TB] falling/any");
        readAt(2'd0, 8'h01);
        ticks(4);
        writeAt(2'd3, 32'hFF, 8'h01);
        tick();
        readAt(2'd3, 8'h00);
        ticks(4);
        checkOutput("fall_rise", rdOut[0], 32'h0);
        checkOutput("fall_fall", rdOut[1], 32'h1);
        checkOutput("fall_any", rdOut[2], 32'h1);
        writeAt(2'd3, 32'hFF, 8'h00);
        tick();
        readAt(2'd3, 8'h01);
        ticks(4);
        checkOutput("rise_rise", rdOut[0], 32'h1);
        checkOutput("rise_fall", rdOut[1], 32'h0);
        checkOutput("rise_any", rdOut[2], 32'h1);

        // Reset mid-operation with mask 0xFF and edgecapture 0x3.
        $display("[TB] reset mid-run");
        writeAt(2'd2, 32'hFF, 8'h00);
        ticks(4);
        writeAt(2'd3, 32'hFF, 8'h00);
        tick();
        readAt(2'd3, 8'h03);
        ticks(4);
        checkOutput("pre_rst_ec", rdOut[0], 32'h3);
        checkOutput("pre_rst_irq", {31'b0, irqOut[0]}, 32'h1);
        asyncReset();
        ticks(2);
        reset = 1'b0;
        readAt(2'd1, 8'h03);
        tick();
        checkOutput("post_rsvd", rdOut[0], 32'h0);
        readAt(2'd2, 8'h03);
        tick();
        checkOutput("post_mask", rdOut[0], 32'h0);
        readAt(2'd3, 8'h03);
        tick();
        checkOutput("post_ec", rdOut[0], 32'h0);
        ticks(3);

        // Randomised traffic.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] inp;
            inp = in_port;
            if ($urandom_range(0, 2) == 0) inp = W'($urandom);
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          $urandom & $urandom, inp);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
